// File: rtl/hb_pkg.sv
// hb_pkg: shared definitions for the halfband interpolator family.
//   - Default widths DW/CW/OW/AW used as parameter defaults.
//   - Q1.17 coefficients of the 11-tap halfband prototype. The odd taps
//     other than the centre tap are zero and have no constants.
//   - hb_state_t: the sequencing states, shared with later interpolator
//     stages.
package hb_pkg;

    localparam int DW = 18;  // input sample width
    localparam int CW = 18;  // coefficient width (Q1.17)
    localparam int OW = 18;  // output sample width, equal to DW
    localparam int AW = 40;  // accumulator width, at least DW+1+CW+2

    // Symmetric taps: C0 pairs (d0,d5), C2 pairs (d1,d4), C4 pairs (d2,d3).
    localparam logic signed [17:0] C0 = 18'sd1042;
    localparam logic signed [17:0] C2 = -18'sd7125;
    localparam logic signed [17:0] C4 = 18'sd38855;
    // Centre tap, exactly 0.5.
    localparam logic signed [17:0] C5 = 18'sd65536;

    typedef enum logic [2:0] {
        IDLE,
        MAC0,
        MAC1,
        MAC2,
        OUT_EVEN,
        OUT_ODD
    } hb_state_t;

endpackage

// File: rtl/hb_preadd_mac.sv
// hb_preadd_mac: one symmetric-tap step of the halfband filter.
//   acc_out <= (clr ? 0 : acc_in) + coef * (a + b)
// The pre-add is sign-extended to DW+1 bits and the product is kept at its
// full DW+1+CW bits, so nothing is truncated before the accumulator.
// Driving coef = 0 with clr = 0 and acc_in = acc_out holds the accumulator.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears acc_out)
//   a, b            paired delay-line taps, signed DW
//   coef            tap coefficient, signed CW (Q1.17)
//   acc_in          running sum to add to, signed AW
//   clr             start a new sum (ignore acc_in)
//   acc_out         registered accumulator, signed AW
module hb_preadd_mac
    import hb_pkg::*;
#(
    parameter int DW = hb_pkg::DW,
    parameter int CW = hb_pkg::CW,
    parameter int AW = hb_pkg::AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    input  logic signed [CW-1:0] coef,
    input  logic signed [AW-1:0] acc_in,
    input  logic                 clr,
    output logic signed [AW-1:0] acc_out
);

    localparam int PW = DW + 1 + CW;

    logic signed [DW:0]   pre;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] base;

    assign pre  = (DW+1)'(a) + (DW+1)'(b);
    assign prod = PW'(pre) * PW'(coef);
    assign base = clr ? '0 : acc_in;

    // NOTE: clocked state is written with <= so every flop samples the
    // values from before the edge; = here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out <= '0;
        end else begin
            acc_out <= base + AW'(prod);
        end
    end

endmodule

// File: rtl/halfband_interp2.sv
// halfband_interp2: polyphase 2x halfband interpolator.
// Each accepted input x[n] produces an even output y[2n] from three
// symmetric multiply-accumulate steps and an odd output y[2n+1] that is the
// centre tap alone. With the x2 interpolation gain, that centre tap (0.5)
// makes the odd output equal d2 exactly.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   s_valid/s_ready    input handshake; s_ready is high only in IDLE
//   s_data             input sample, signed DW
//   m_valid/m_ready    output handshake; outputs hold while stalled
//   m_data             output sample, signed OW (OW must equal DW)
//   m_phase            0 = even output, 1 = odd output
module halfband_interp2
    import hb_pkg::*;
#(
    parameter int DW = hb_pkg::DW,
    parameter int CW = hb_pkg::CW,
    parameter int OW = hb_pkg::OW,
    parameter int AW = hb_pkg::AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [OW-1:0] m_data,
    output logic                 m_phase
);

    // Width of the accumulator after the >>>16 that applies the x2 gain
    // together with the Q1.17 scaling.
    localparam int SW = AW - 16;
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    // 2*C5 is a power of two, so the odd phase is a shift of d2 (zero for 0.5).
    localparam int CENTRE_SHIFT = $clog2(int'(C5)) - 16;

    hb_state_t            state;
    logic signed [DW-1:0] dly [6];

    logic signed [DW-1:0] mac_a;
    logic signed [DW-1:0] mac_b;
    logic signed [CW-1:0] mac_coef;
    logic                 mac_clr;
    logic signed [AW-1:0] acc;

    logic signed [AW-1:0] rounded;
    logic signed [SW-1:0] scaled;
    logic signed [OW-1:0] even_data;
    logic signed [OW-1:0] odd_data;

    assign s_ready = (state == IDLE);

    // Sequencer and delay line. The delay line moves only on an input
    // handshake, so it stays valid for the odd output and for backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            m_phase <= 1'b0;
            // NOTE: the delay line is only six registers and must read as
            // zero history after reset, so it is reset like any other flop.
            for (int k = 0; k < 6; k++) begin
                dly[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        dly[0] <= s_data;
                        for (int k = 1; k < 6; k++) begin
                            dly[k] <= dly[k-1];
                        end
                        state <= MAC0;
                    end
                end
                MAC0: state <= MAC1;
                MAC1: state <= MAC2;
                MAC2: begin
                    state   <= OUT_EVEN;
                    m_valid <= 1'b1;
                    m_phase <= 1'b0;
                end
                OUT_EVEN: begin
                    if (m_ready) begin
                        state   <= OUT_ODD;
                        m_phase <= 1'b1;
                    end
                end
                OUT_ODD: begin
                    if (m_ready) begin
                        state   <= IDLE;
                        m_valid <= 1'b0;
                        m_phase <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                    m_phase <= 1'b0;
                end
            endcase
        end
    end

    // Operand selection for the shared MAC. Outside the MAC states the
    // coefficient is zero, so the accumulator holds its value.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        mac_a    = '0;
        mac_b    = '0;
        mac_coef = '0;
        mac_clr  = 1'b0;
        case (state)
            MAC0: begin
                mac_a    = dly[0];
                mac_b    = dly[5];
                mac_coef = CW'(C0);
                mac_clr  = 1'b1;
            end
            MAC1: begin
                mac_a    = dly[1];
                mac_b    = dly[4];
                mac_coef = CW'(C2);
            end
            MAC2: begin
                mac_a    = dly[2];
                mac_b    = dly[3];
                mac_coef = CW'(C4);
            end
            default: ;
        endcase
    end

    hb_preadd_mac #(
        .DW (DW),
        .CW (CW),
        .AW (AW)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .a       (mac_a),
        .b       (mac_b),
        .coef    (mac_coef),
        .acc_in  (acc),
        .clr     (mac_clr),
        .acc_out (acc)
    );

    // Round half-up, scale and saturate the even-phase sum.
    assign rounded = acc + AW'(32'sd32768);
    assign scaled  = SW'(rounded >>> 16);

    always_comb begin
        if (scaled > SAT_MAX) begin
            even_data = SAT_MAX[OW-1:0];
        end else if (scaled < SAT_MIN) begin
            even_data = SAT_MIN[OW-1:0];
        end else begin
            even_data = scaled[OW-1:0];
        end
    end

    assign odd_data = OW'(dly[2] <<< CENTRE_SHIFT);

    // Both sources are stable while stalled (acc and the delay line only
    // move in other states), so the output holds under backpressure.
    always_comb begin
        m_data = '0;
        if (m_valid) begin
            m_data = m_phase ? odd_data : even_data;
        end
    end

endmodule

// File: tb/tb_halfband_interp2.sv
// tb_halfband_interp2: directed self-checking bench for halfband_interp2.
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// acts on the rising edge.
module tb_halfband_interp2;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic               s_ready;
    logic signed [17:0] s_data;
    logic               m_valid;
    logic               m_ready;
    logic signed [17:0] m_data;
    logic               m_phase;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    halfband_interp2 dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_phase (m_phase)
    );

    // Expected impulse response for input 65536 followed by zeros.
    int imp_even [8] = '{1042, -7125, 38855, 38855, -7125, 1042, 0, 0};
    int imp_odd  [8] = '{0, 0, 65536, 0, 0, 0, 0, 0};

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Present one sample in IDLE; returns on the falling edge after acceptance.
    task automatic send(input int x);
        int n = 0;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("s_ready before send", int'(s_ready), 1);
        s_valid = 1'b1;
        s_data  = 18'(x);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Wait (bounded) for m_valid, sample it, and step past the consuming edge
    // when m_ready is high. lat counts falling edges waited.
    task automatic get(output int v, output int ph, output int lat);
        lat = 0;
        while (!m_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("m_valid timeout", int'(m_valid), 1);
        v  = int'(m_data);
        ph = int'(m_phase);
        if (m_ready) @(negedge clk);
    endtask

    task automatic step(input string tag, input int x, input bit chk,
                        input int ev, input int ov);
        int v, ph, lat;
        send(x);
        get(v, ph, lat);
        check({tag, " even latency"}, lat, 3);
        check({tag, " even phase"}, ph, 0);
        if (chk) check({tag, " even data"}, v, ev);
        get(v, ph, lat);
        check({tag, " odd latency"}, lat, 0);
        check({tag, " odd phase"}, ph, 1);
        if (chk) check({tag, " odd data"}, v, ov);
    endtask

    task automatic impulse_run(input string tag);
        for (int k = 0; k < 8; k++) begin
            step($sformatf("%s[%0d]", tag, k), (k == 0) ? 65536 : 0, 1'b1,
                 imp_even[k], imp_odd[k]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v, ph, lat, held;

        // Reset held over three edges with s_valid high: nothing accepted.
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 18'sd12345;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset m_valid", int'(m_valid), 0);
        check("reset m_data", int'(m_data), 0);
        check("reset s_ready", int'(s_ready), 1);
        rst     = 1'b0;
        s_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post-reset idle m_valid", int'(m_valid), 0);
        end

        // Impulse response.
        impulse_run("impulse");

        // DC: ten inputs of 10000; backpressure exercised on the 8th.
        for (int k = 1; k <= 10; k++) begin
            if (k == 8) begin
                send(10000);
                m_ready = 1'b0;
                get(v, ph, lat);
                check("bp even latency", lat, 3);
                check("bp even data", v, 10001);
                held = v;
                for (int i = 0; i < 5; i++) begin
                    if (i == 2) begin
                        s_valid = 1'b1;
                        s_data  = -18'sd50000;
                    end
                    @(negedge clk);
                    s_valid = 1'b0;
                    check("bp m_valid held", int'(m_valid), 1);
                    check("bp m_data held", int'(m_data), held);
                    check("bp m_phase held", int'(m_phase), 0);
                    check("bp s_ready low", int'(s_ready), 0);
                end
                m_ready = 1'b1;
                @(negedge clk);
                check("bp odd m_valid", int'(m_valid), 1);
                check("bp odd phase", int'(m_phase), 1);
                check("bp odd data", int'(m_data), 10000);
                @(negedge clk);
                check("bp after odd m_valid", int'(m_valid), 0);
                check("bp after odd s_ready", int'(s_ready), 1);
            end else begin
                step($sformatf("dc[%0d]", k), 10000, k >= 6, 10001, 10000);
            end
        end

        // Positive saturation: 131087 clips to 131071.
        for (int k = 1; k <= 6; k++) begin
            step($sformatf("satpos[%0d]", k), 131071, k == 6, 131071, 131071);
        end

        // Negative saturation: -131088 clips to -131072.
        for (int k = 1; k <= 6; k++) begin
            step($sformatf("satneg[%0d]", k), -131072, k == 6, -131072, -131072);
        end

        // Reset during MAC1 of an impulse: no output, history cleared.
        send(65536);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset m_valid", int'(m_valid), 0);
        check("midreset s_ready", int'(s_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midreset no output", int'(m_valid), 0);
        end
        impulse_run("impulse2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
